// File: rtl/pin_entry_buffer.sv
// pin_entry_buffer
//   Collects decimal keypad digits into an N_DIGITS right-aligned buffer
//   (newest digit in [3:0], unused nibbles hold 4'hE). Supports backspace,
//   clear, a minimum-length check on enter and an inactivity auto-clear.
//   An accepted enter freezes the buffer and raises pin_status for
//   STATUS_CYCLES cycles, then the buffer is flushed.
//
//   Ports
//     clk        : system clock, rising edge
//     rst        : asynchronous reset, active low
//     key_valid  : keypad strobe, rising edge acted on
//     key_code   : 0-9 digit, A backspace, B clear, F enter, others ignored
//     pin_digits : packed digit buffer, 4*N_DIGITS bits
//     pin_count  : number of valid digits
//     pin_status : high for STATUS_CYCLES cycles after an accepted enter
//     reject     : 1-cycle pulse, enter with too few digits
//     timeout    : 1-cycle pulse, inactivity auto-clear

// One buffer nibble. All nibbles move together; the neighbours feed the
// shift paths, so the whole buffer is a bidirectional nibble shifter.
module pin_entry_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       shl_i,
  input  logic       shr_i,
  input  logic       clr_i,
  input  logic [3:0] lower_i,
  input  logic [3:0] upper_i,
  output logic [3:0] nib_o
);
  logic [3:0] nib_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       nib_q <= 4'hE;
    else if (clr_i) nib_q <= 4'hE;
    else if (shl_i) nib_q <= lower_i;
    else if (shr_i) nib_q <= upper_i;
  end

  assign nib_o = nib_q;
endmodule

module pin_entry_buffer #(
  parameter int N_DIGITS       = 4,
  parameter int MIN_DIGITS     = 4,
  parameter int STATUS_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  output logic [4*N_DIGITS-1:0]         pin_digits,
  output logic [$clog2(N_DIGITS+1)-1:0] pin_count,
  output logic                          pin_status,
  output logic                          reject,
  output logic                          timeout
);
  localparam int CW = $clog2(N_DIGITS+1);
  localparam int SW = $clog2(STATUS_CYCLES+1);
  localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [IW-1:0] IDLE_LAST = TO_EN ? IW'(TIMEOUT_CYCLES-1) : '0;

  localparam logic [3:0] KEY_BS  = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_SUBMIT, S_FLUSH} state_t;

  // Decoded key event; all fields are zero unless a fresh press arrived.
  typedef struct packed {
    logic dig;
    logic bs;
    logic clr;
    logic ent;
    logic any;
  } key_ev_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic            status_q, status_d;
  logic            reject_q, reject_d;
  logic            timeout_q, timeout_d;
  logic            key_prev_q;
  key_ev_t         kev;
  logic            shl, shr, clr;

  logic [N_DIGITS-1:0][3:0] buf_q;

  // Edge detect: a held key produces one event.
  always_comb begin
    kev     = '0;
    kev.any = key_valid & ~key_prev_q;
    kev.dig = kev.any & (key_code <= 4'd9);
    kev.bs  = kev.any & (key_code == KEY_BS);
    kev.clr = kev.any & (key_code == KEY_CLR);
    kev.ent = kev.any & (key_code == KEY_ENT);
  end

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_slot
    logic [3:0] lower, upper;
    if (i == 0) begin : g_lo
      assign lower = key_code;
    end else begin : g_lo
      assign lower = buf_q[i-1];
    end
    if (i == N_DIGITS-1) begin : g_up
      assign upper = 4'hE;
    end else begin : g_up
      assign upper = buf_q[i+1];
    end
    pin_entry_slot u_slot (
      .clk     (clk),
      .rst     (rst),
      .shl_i   (shl),
      .shr_i   (shr),
      .clr_i   (clr),
      .lower_i (lower),
      .upper_i (upper),
      .nib_o   (buf_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      scnt_q     <= '0;
      idle_q     <= '0;
      status_q   <= 1'b0;
      reject_q   <= 1'b0;
      timeout_q  <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      scnt_q     <= scnt_d;
      idle_q     <= idle_d;
      status_q   <= status_d;
      reject_q   <= reject_d;
      timeout_q  <= timeout_d;
      key_prev_q <= key_valid;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scnt_d    = scnt_q;
    idle_d    = '0;
    status_d  = status_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    shl       = 1'b0;
    shr       = 1'b0;
    clr       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Buffer is all 4'hE here, so a left shift leaves just the new digit.
        if (kev.dig) begin
          shl     = 1'b1;
          cnt_d   = CW'(1);
          state_d = S_ENTRY;
        end else if (kev.ent) begin
          reject_d = 1'b1;
        end
      end
      S_ENTRY: begin
        if (kev.any) begin
          // Any press, even an ignored code, restarts the idle window and
          // wins over a coincident expiry.
          if (kev.dig) begin
            shl = 1'b1;
            if (cnt_q != CW'(N_DIGITS)) cnt_d = cnt_q + 1'b1;
          end else if (kev.bs) begin
            shr   = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = S_IDLE;
          end else if (kev.clr) begin
            clr     = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (kev.ent) begin
            if (cnt_q >= CW'(MIN_DIGITS)) begin
              state_d  = S_SUBMIT;
              status_d = 1'b1;
              scnt_d   = SW'(1);
            end else begin
              reject_d = 1'b1;
            end
          end
        end else if (TO_EN && idle_q == IDLE_LAST) begin
          clr       = 1'b1;
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_SUBMIT: begin
        // scnt_q counts cycles pin_status has already been high; the buffer
        // is cleared on the same edge status drops so FLUSH shows 4'hE.
        if (scnt_q == SW'(STATUS_CYCLES)) begin
          state_d  = S_FLUSH;
          status_d = 1'b0;
          scnt_d   = '0;
          clr      = 1'b1;
          cnt_d    = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        status_d = 1'b0;
        clr      = 1'b1;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pin_digits = buf_q;
  assign pin_count  = cnt_q;
  assign pin_status = status_q;
  assign reject     = reject_q;
  assign timeout    = TO_EN ? timeout_q : 1'b0;

endmodule

// File: tb/tb_pin_entry_buffer.sv
// Bench for pin_entry_buffer: two instances (N=4/T=20 and N=6/no timeout),
// directed scenario tasks plus a randomized run against a queue-free
// digit-list reference model.
module tb_pin_entry_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        kv_a, kv_b;
  logic [3:0]  kc_a, kc_b;
  logic [15:0] dig_a;
  logic [2:0]  cnt_a;
  logic        st_a, rj_a, to_a;
  logic [23:0] dig_b;
  logic [2:0]  cnt_b;
  logic        st_b, rj_b, to_b;
  int          checks = 0;
  int          errors = 0;

  pin_entry_buffer #(.N_DIGITS(4), .MIN_DIGITS(4), .STATUS_CYCLES(2), .TIMEOUT_CYCLES(20)) dut_a (
    .clk(clk), .rst(rst), .key_valid(kv_a), .key_code(kc_a),
    .pin_digits(dig_a), .pin_count(cnt_a), .pin_status(st_a), .reject(rj_a), .timeout(to_a)
  );

  pin_entry_buffer #(.N_DIGITS(6), .MIN_DIGITS(4), .STATUS_CYCLES(3), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .key_valid(kv_b), .key_code(kc_b),
    .pin_digits(dig_b), .pin_count(cnt_b), .pin_status(st_b), .reject(rj_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_ENTRY = 1, M_SUBMIT = 2, M_FLUSH = 3;

  typedef struct packed {
    int          mode;
    int          cnt;
    logic [31:0] digs;   // digit history, newest in [3:0]
    int          idle;
    int          hold;   // status cycles still to go
    bit          prev;
    bit          status;
    bit          reject;
    bit          tmo;
  } model_t;

  model_t ma, mb;

  function automatic model_t mreset();
    model_t r;
    r = '0;
    r.mode = M_IDLE;
    return r;
  endfunction

  function automatic model_t mstep(model_t m, bit kv, logic [3:0] kc,
                                   int n, int mn, int s, int t);
    model_t r;
    bit ev;
    r = m;
    ev = kv && !m.prev;
    r.prev = kv;
    r.reject = 0;
    r.tmo = 0;
    if (m.mode == M_IDLE) begin
      if (ev && kc <= 9) begin
        r.digs = {28'd0, kc}; r.cnt = 1; r.mode = M_ENTRY; r.idle = 0;
      end else if (ev && kc == 4'hF) r.reject = 1;
    end else if (m.mode == M_ENTRY) begin
      if (ev) begin
        r.idle = 0;
        if (kc <= 9) begin
          r.digs = (m.digs << 4) | {28'd0, kc};
          if (m.cnt < n) r.cnt = m.cnt + 1;
        end else if (kc == 4'hA) begin
          r.digs = m.digs >> 4;
          r.cnt = m.cnt - 1;
          if (r.cnt == 0) r.mode = M_IDLE;
        end else if (kc == 4'hB) begin
          r.cnt = 0; r.mode = M_IDLE;
        end else if (kc == 4'hF) begin
          if (m.cnt >= mn) begin r.mode = M_SUBMIT; r.status = 1; r.hold = s; end
          else r.reject = 1;
        end
      end else if (t > 0 && m.idle == t - 1) begin
        r.cnt = 0; r.tmo = 1; r.mode = M_IDLE; r.idle = 0;
      end else r.idle = m.idle + 1;
    end else if (m.mode == M_SUBMIT) begin
      r.hold = m.hold - 1;
      if (r.hold == 0) begin r.mode = M_FLUSH; r.status = 0; r.cnt = 0; end
    end else r.mode = M_IDLE;
    return r;
  endfunction

  // Visible buffer: newest cnt digits, remaining positions 4'hE.
  function automatic logic [31:0] mdisp(model_t m, int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[4*i +: 4] = (i < m.cnt) ? m.digs[4*i +: 4] : 4'hE;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= mstep(ma, kv_a, kc_a, 4, 4, 2, 20);
      mb <= mstep(mb, kv_b, kc_b, 6, 4, 3, 0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input bit b, input logic [3:0] code);
    @(negedge clk);
    if (b) begin kv_b = 1'b1; kc_b = code; end
    else   begin kv_a = 1'b1; kc_a = code; end
    @(negedge clk);
    kv_a = 1'b0;
    kv_b = 1'b0;
  endtask

  function automatic logic [3:0] rand_code();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 5)      return 4'($urandom_range(0, 9));
    else if (sel == 6) return 4'hA;
    else if (sel <= 8) return 4'hF;
    else               return 4'($urandom_range(0, 15));
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset;
    checks++;
    if ({dig_a, cnt_a, st_a, rj_a, to_a} !== {16'hEEEE, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_a got dig=%h cnt=%0d st=%b rj=%b to=%b exp dig=eeee cnt=0 st=0 rj=0 to=0",
               dig_a, cnt_a, st_a, rj_a, to_a);
    end
    checks++;
    if ({dig_b, cnt_b, st_b, rj_b, to_b} !== {24'hEEEEEE, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_b got dig=%h cnt=%0d st=%b rj=%b to=%b exp dig=eeeeee cnt=0 st=0 rj=0 to=0",
               dig_b, cnt_b, st_b, rj_b, to_b);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dig_a, cnt_a, st_a} !== {16'hEEEE, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release got dig=%h cnt=%0d st=%b exp eeee 0 0", dig_a, cnt_a, st_a);
    end
  endtask

  task automatic test_submit;
    int n;
    press(0, 1); press(0, 2); press(0, 3); press(0, 4);
    checks++;
    if ({dig_a, cnt_a, st_a} !== {16'h1234, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL submit_fill got dig=%h cnt=%0d st=%b exp 1234 4 0", dig_a, cnt_a, st_a);
    end
    press(0, 4'hF);
    checks++;
    if ({dig_a, cnt_a, st_a} !== {16'h1234, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL submit_status got dig=%h cnt=%0d st=%b exp 1234 4 1", dig_a, cnt_a, st_a);
    end
    n = 0;
    while (st_a && n < 20) begin n++; @(negedge clk); end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL submit_status_len got %0d cycles exp 2", n);
    end
    checks++;
    if ({dig_a, cnt_a, st_a} !== {16'hEEEE, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL submit_flush got dig=%h cnt=%0d st=%b exp eeee 0 0", dig_a, cnt_a, st_a);
    end
    @(negedge clk);
  endtask

  task automatic test_rolling;
    int n;
    for (int d = 1; d <= 6; d++) press(0, 4'(d));
    press(0, 4'hF);
    checks++;
    if ({dig_a, cnt_a, st_a} !== {16'h3456, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL rolling_window got dig=%h cnt=%0d st=%b exp 3456 4 1", dig_a, cnt_a, st_a);
    end
    n = 0;
    while (st_a && n < 20) begin n++; @(negedge clk); end
    @(negedge clk);
    press(0, 1);
    @(negedge clk);
    kv_a = 1'b1; kc_a = 4'd7;
    repeat (10) @(negedge clk);
    kv_a = 1'b0;
    checks++;
    if ({dig_a, cnt_a} !== {16'hEE17, 3'd2}) begin
      errors++;
      $display("FAIL held_key got dig=%h cnt=%0d exp ee17 2", dig_a, cnt_a);
    end
    press(0, 4'hB);
  endtask

  task automatic test_reject;
    int n;
    press(0, 1); press(0, 2); press(0, 3); press(0, 4'hF);
    checks++;
    if ({dig_a, cnt_a, st_a, rj_a} !== {16'hE123, 3'd3, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reject_pulse got dig=%h cnt=%0d st=%b rj=%b exp e123 3 0 1", dig_a, cnt_a, st_a, rj_a);
    end
    @(negedge clk);
    checks++;
    if ({rj_a, st_a} !== 2'b00) begin
      errors++;
      $display("FAIL reject_width got rj=%b st=%b exp 0 0", rj_a, st_a);
    end
    press(0, 4); press(0, 4'hF);
    checks++;
    if ({dig_a, cnt_a, st_a} !== {16'h1234, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL reject_then_accept got dig=%h cnt=%0d st=%b exp 1234 4 1", dig_a, cnt_a, st_a);
    end
    n = 0;
    while (st_a && n < 20) begin n++; @(negedge clk); end
    @(negedge clk);
  endtask

  task automatic test_backspace;
    press(0, 1); press(0, 2); press(0, 3); press(0, 4'hA); press(0, 4'hA);
    checks++;
    if ({dig_a, cnt_a} !== {16'hEEE1, 3'd1}) begin
      errors++;
      $display("FAIL backspace_two got dig=%h cnt=%0d exp eee1 1", dig_a, cnt_a);
    end
    press(0, 4'hA);
    checks++;
    if ({dig_a, cnt_a} !== {16'hEEEE, 3'd0}) begin
      errors++;
      $display("FAIL backspace_empty got dig=%h cnt=%0d exp eeee 0", dig_a, cnt_a);
    end
    press(0, 5);
    checks++;
    if ({dig_a, cnt_a} !== {16'hEEE5, 3'd1}) begin
      errors++;
      $display("FAIL digit_after_bs got dig=%h cnt=%0d exp eee5 1", dig_a, cnt_a);
    end
    press(0, 4'hB);
    checks++;
    if ({dig_a, cnt_a, st_a, rj_a, to_a} !== {16'hEEEE, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL clear got dig=%h cnt=%0d st=%b rj=%b to=%b exp eeee 0 0 0 0",
               dig_a, cnt_a, st_a, rj_a, to_a);
    end
  endtask

  task automatic test_timeout;
    int n;
    press(0, 7);
    n = 0;
    while (!to_a && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL timeout_delay got %0d cycles exp 20", n);
    end
    checks++;
    if ({dig_a, cnt_a} !== {16'hEEEE, 3'd0}) begin
      errors++;
      $display("FAIL timeout_clear got dig=%h cnt=%0d exp eeee 0", dig_a, cnt_a);
    end
    @(negedge clk);
    checks++;
    if (to_a !== 1'b0) begin
      errors++;
      $display("FAIL timeout_width got to=%b exp 0", to_a);
    end
    // Key lands in the cycle the idle counter expires: it must win.
    press(0, 7);
    repeat (18) @(negedge clk);
    @(negedge clk);
    kv_a = 1'b1; kc_a = 4'd3;
    @(negedge clk);
    kv_a = 1'b0;
    checks++;
    if ({dig_a, cnt_a, to_a} !== {16'hEE73, 3'd2, 1'b0}) begin
      errors++;
      $display("FAIL timeout_race got dig=%h cnt=%0d to=%b exp ee73 2 0", dig_a, cnt_a, to_a);
    end
    press(0, 4'hB);
  endtask

  task automatic test_n6_reset;
    press(1, 9); press(1, 8); press(1, 7); press(1, 6); press(1, 5); press(1, 4'hF);
    checks++;
    if ({dig_b, cnt_b, st_b} !== {24'hE98765, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL n6_submit got dig=%h cnt=%0d st=%b exp e98765 5 1", dig_b, cnt_b, st_b);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({dig_b, cnt_b, st_b, rj_b, to_b} !== {24'hEEEEEE, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL n6_async_reset got dig=%h cnt=%0d st=%b rj=%b to=%b exp eeeeee 0 0 0 0",
               dig_b, cnt_b, st_b, rj_b, to_b);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({st_b, cnt_b} !== {1'b0, 3'd0}) begin
        errors++;
        $display("FAIL n6_post_reset cyc=%0d got st=%b cnt=%0d exp 0 0", i, st_b, cnt_b);
      end
    end
  endtask

  task automatic test_random;
    int gap_a, gap_b;
    logic [31:0] ea, eb;
    gap_a = 0;
    gap_b = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      ea = mdisp(ma, 4);
      eb = mdisp(mb, 6);
      checks++;
      if ({dig_a, cnt_a, st_a, rj_a, to_a} !==
          {ea[15:0], 3'(ma.cnt), ma.status, ma.reject, ma.tmo}) begin
        errors++;
        $display("FAIL rand_a cyc=%0d got dig=%h cnt=%0d st=%b rj=%b to=%b exp dig=%h cnt=%0d st=%b rj=%b to=%b",
                 c, dig_a, cnt_a, st_a, rj_a, to_a, ea[15:0], ma.cnt, ma.status, ma.reject, ma.tmo);
      end
      checks++;
      if ({dig_b, cnt_b, st_b, rj_b, to_b} !==
          {eb[23:0], 3'(mb.cnt), mb.status, mb.reject, mb.tmo}) begin
        errors++;
        $display("FAIL rand_b cyc=%0d got dig=%h cnt=%0d st=%b rj=%b to=%b exp dig=%h cnt=%0d st=%b rj=%b to=%b",
                 c, dig_b, cnt_b, st_b, rj_b, to_b, eb[23:0], mb.cnt, mb.status, mb.reject, mb.tmo);
      end
      if (gap_a > 0) begin
        gap_a--; kv_a = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 2) gap_a = $urandom_range(15, 30);
        kv_a = ($urandom_range(0, 2) == 0);
        kc_a = rand_code();
      end
      if (gap_b > 0) begin
        gap_b--; kv_b = 1'b0;
      end else begin
        if ($urandom_range(0, 99) < 2) gap_b = $urandom_range(15, 30);
        kv_b = ($urandom_range(0, 2) == 0);
        kc_b = rand_code();
      end
    end
    kv_a = 1'b0;
    kv_b = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    kv_a = 1'b0; kc_a = 4'h0;
    kv_b = 1'b0; kc_b = 4'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_submit();
    test_rolling();
    test_reject();
    test_backspace();
    test_timeout();
    test_n6_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
